// File: rtl/speed_step_ctrl.sv
// speed_step_ctrl: steps the rotary speed FSM to a requested target with confirmed single-cycle L/R pulses.
// Optional SPEED_STEP_CNT_EN adds a saturating step_cnt output counting issued pulses.
module speed_step_ctrl #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_speed,
    output logic       req_ready,
    input  logic       speed_0,
    input  logic       speed_1,
    input  logic       speed_2,
    input  logic       speed_3,
    output logic       L,
    output logic       R,
    output logic       busy,
    output logic       done,
`ifdef SPEED_STEP_CNT_EN
    output logic [7:0] step_cnt,
`endif
    output logic       err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] G1 = CW'(GAP - 1);
    localparam logic [CW-1:0] T1 = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CHECK, PULSE, WAIT, DONE, ERR} state_t;
    state_t st, nxt;

    logic [1:0]    target, expected, cur, diff;
    logic [CW-1:0] cnt;
    logic          dir_l, legal;
    logic [3:0]    fb;

    assign fb    = {speed_3, speed_2, speed_1, speed_0};
    assign legal = fb == 4'b0001 || fb == 4'b0010 || fb == 4'b0100 || fb == 4'b1000;
    assign cur   = {fb[3] | fb[2], fb[3] | fb[1]};
    assign diff  = target - cur;

    assign req_ready = st == IDLE;
    assign busy      = st == CHECK || st == PULSE || st == WAIT;
    assign L         = st == PULSE && dir_l;
    assign R         = st == PULSE && !dir_l;
    assign done      = st == DONE;
    assign err       = st == ERR;

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = req_valid ? CHECK : IDLE;
            CHECK:   nxt = !legal ? ERR : cur == target ? DONE : PULSE;
            PULSE:   nxt = WAIT;
            WAIT:    nxt = !legal ? ERR : (cur == expected && cnt >= G1) ? CHECK : cnt == T1 ? ERR : WAIT;
            DONE:    nxt = IDLE;
            default: nxt = ERR;
        endcase
    end

`ifdef SPEED_STEP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            step_cnt <= '0;
        else if (st == PULSE && step_cnt != 8'hff)
            step_cnt <= step_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            target   <= '0;
            expected <= '0;
            dir_l    <= 1'b0;
            cnt      <= '0;
        end else begin
            st  <= nxt;
            cnt <= st == WAIT ? cnt + 1'b1 : '0;
            if (st == IDLE && req_valid)
                target <= req_speed;
            if (st == CHECK) begin
                dir_l    <= diff == 2'd3;
                expected <= diff == 2'd3 ? cur - 2'd1 : cur + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_speed_step_ctrl.sv
// tb_speed_step_ctrl: directed checks of speed_step_ctrl against a behavioural rotary speed FSM.
module tb_speed_step_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_speed = 2'd0;
    logic       req_ready, L, R, busy, done, err;
    logic       speed_0, speed_1, speed_2, speed_3;
`ifdef SPEED_STEP_CNT_EN
    logic [7:0] step_cnt;
`endif
    logic [1:0] sp, init_sp = 2'd0;
    logic       frz = 1'b0, force_en = 1'b0;
    logic [3:0] force_fb = 4'b0000, fb;
    int         checks = 0, fails = 0;

    speed_step_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_speed(req_speed),
        .req_ready(req_ready), .speed_0(speed_0), .speed_1(speed_1),
        .speed_2(speed_2), .speed_3(speed_3), .L(L), .R(R), .busy(busy),
        .done(done),
`ifdef SPEED_STEP_CNT_EN
        .step_cnt(step_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    // Rotary speed FSM model: one-cycle feedback delay, resets alongside the DUT.
    always @(posedge clk)
        if (reset) sp <= init_sp;
        else if (!frz) sp <= R ? sp + 2'd1 : L ? sp - 2'd1 : sp;

    assign fb = force_en ? force_fb : 4'b0001 << sp;
    assign {speed_3, speed_2, speed_1, speed_0} = fb;

    task automatic do_reset(input logic [1:0] s);
        init_sp = s;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic run_req(input logic [1:0] s, input int maxc, output int cyc, output int nl,
                           output int nr, output logic gd, output logic ge, output logic both);
        cyc = 0; nl = 0; nr = 0; gd = 0; ge = 0; both = 0;
        req_speed = s;
        req_valid = 1'b1;
        @(negedge clk) req_valid = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cyc++;
            if (L) nl++;
            if (R) nr++;
            if (L && R) both = 1;
            if (done) begin gd = 1; break; end
            if (err) begin ge = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset(2'd0);
        checks++;
        if ({req_ready, L, R, busy, done, err} !== 6'b100000) begin
            fails++; $display("FAIL reset_outputs: got %b expected 100000", {req_ready, L, R, busy, done, err});
        end
    endtask

    task automatic test_two_up;
        int cyc, nl, nr; logic gd, ge, both;
        do_reset(2'd0);
        run_req(2'd2, 40, cyc, nl, nr, gd, ge, both);
        checks++; if (gd !== 1'b1) begin fails++; $display("FAIL up2_done: got %b expected 1", gd); end
        checks++; if (cyc != 10) begin fails++; $display("FAIL up2_latency: got %0d expected 10", cyc); end
        checks++; if (nr != 2) begin fails++; $display("FAIL up2_rcount: got %0d expected 2", nr); end
        checks++; if (nl != 0) begin fails++; $display("FAIL up2_lcount: got %0d expected 0", nl); end
        checks++; if (sp !== 2'd2) begin fails++; $display("FAIL up2_position: got %0d expected 2", sp); end
        checks++; if (both !== 1'b0) begin fails++; $display("FAIL up2_lr_overlap: got %b expected 0", both); end
`ifdef SPEED_STEP_CNT_EN
        checks++; if (step_cnt !== 8'd2) begin fails++; $display("FAIL up2_step_cnt: got %0d expected 2", step_cnt); end
`endif
    endtask

    task automatic test_wrap_down;
        int cyc, nl, nr; logic gd, ge, both;
        do_reset(2'd0);
        run_req(2'd3, 40, cyc, nl, nr, gd, ge, both);
        checks++; if (gd !== 1'b1) begin fails++; $display("FAIL wrap_done: got %b expected 1", gd); end
        checks++; if (cyc != 6) begin fails++; $display("FAIL wrap_latency: got %0d expected 6", cyc); end
        checks++; if (nl != 1) begin fails++; $display("FAIL wrap_lcount: got %0d expected 1", nl); end
        checks++; if (nr != 0) begin fails++; $display("FAIL wrap_rcount: got %0d expected 0", nr); end
        checks++; if (sp !== 2'd3) begin fails++; $display("FAIL wrap_position: got %0d expected 3", sp); end
    endtask

    task automatic test_same;
        int cyc, nl, nr; logic gd, ge, both;
        do_reset(2'd1);
        run_req(2'd1, 20, cyc, nl, nr, gd, ge, both);
        checks++; if (gd !== 1'b1) begin fails++; $display("FAIL same_done: got %b expected 1", gd); end
        checks++; if (cyc != 2) begin fails++; $display("FAIL same_latency: got %0d expected 2", cyc); end
        checks++; if (nl + nr != 0) begin fails++; $display("FAIL same_pulses: got %0d expected 0", nl + nr); end
        checks++; if ({req_ready, busy} !== 2'b00) begin fails++; $display("FAIL same_ready_in_done: got %b expected 00", {req_ready, busy}); end
        @(negedge clk);
        checks++; if ({req_ready, done} !== 2'b10) begin fails++; $display("FAIL same_ready_after: got %b expected 10", {req_ready, done}); end
    endtask

    task automatic test_timeout;
        int cyc, nl, nr, bad; logic gd, ge, both;
        do_reset(2'd0);
        frz = 1'b1;
        run_req(2'd1, 60, cyc, nl, nr, gd, ge, both);
        checks++; if (ge !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b expected 1", ge); end
        checks++; if (cyc != 19) begin fails++; $display("FAIL tmo_latency: got %0d expected 19", cyc); end
        checks++; if (nr != 1 || nl != 0) begin fails++; $display("FAIL tmo_pulses: got R=%0d L=%0d expected R=1 L=0", nr, nl); end
        bad = 0;
        req_valid = 1'b1;
        req_speed = 2'd2;
        repeat (6) begin
            @(negedge clk);
            if ({err, req_ready, busy, L, R} !== 5'b10000) bad++;
        end
        req_valid = 1'b0;
        frz = 1'b0;
        checks++; if (bad != 0) begin fails++; $display("FAIL tmo_sticky: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_illegal;
        int cyc, nl, nr; logic gd, ge, both;
        do_reset(2'd0);
        force_en = 1'b1;
        force_fb = 4'b0101;
        run_req(2'd2, 20, cyc, nl, nr, gd, ge, both);
        force_en = 1'b0;
        checks++; if (ge !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b expected 1", ge); end
        checks++; if (cyc != 2) begin fails++; $display("FAIL illegal_latency: got %0d expected 2", cyc); end
        checks++; if (nl + nr != 0) begin fails++; $display("FAIL illegal_pulses: got %0d expected 0", nl + nr); end
    endtask

    task automatic test_reset_mid;
        int cyc, nl, nr, p; logic gd, ge, both;
        do_reset(2'd0);
        req_speed = 2'd2;
        req_valid = 1'b1;
        @(negedge clk) req_valid = 1'b0;
        @(negedge clk);
        checks++; if (R !== 1'b1) begin fails++; $display("FAIL mid_first_pulse: got %b expected 1", R); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        checks++;
        if ({req_ready, L, R, busy, done, err} !== 6'b100000) begin
            fails++; $display("FAIL mid_reset_outputs: got %b expected 100000", {req_ready, L, R, busy, done, err});
        end
        p = 0;
        repeat (6) begin
            @(negedge clk);
            if (L || R) p++;
        end
        checks++; if (p != 0) begin fails++; $display("FAIL mid_no_second_pulse: got %0d expected 0", p); end
        run_req(2'd0, 20, cyc, nl, nr, gd, ge, both);
        checks++; if (gd !== 1'b1 || cyc != 2) begin fails++; $display("FAIL mid_new_req: got done=%b cyc=%0d expected done=1 cyc=2", gd, cyc); end
        checks++; if (nl + nr != 0) begin fails++; $display("FAIL mid_new_pulses: got %0d expected 0", nl + nr); end
    endtask

    initial begin
        test_reset;
        test_two_up;
        test_wrap_down;
        test_same;
        test_timeout;
        test_illegal;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
